// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at the tail, captures CDB results, retires the
// head in order, flushes on a mispredicted branch at the head, and serves operand lookups.
module reorder_buffer #(
  parameter int ROB_DEPTH = 4,
  localparam int TW = $clog2(ROB_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iq_issue,
  input  logic [4:0]    issue_rd_s,
  input  logic          issue_regf_we,
  output logic          rob_full,
  output logic          rob_empty,
  output logic [TW-1:0] rob_issue_tag,
  output logic [4:0]    rob_issue_rd_s,
  input  logic          cdb_valid,
  input  logic [TW-1:0] cdb_tag,
  input  logic [31:0]   cdb_v,
  input  logic          cdb_mispredict,
  input  logic [31:0]   cdb_target,
  input  logic [TW-1:0] rs1_query_tag,
  input  logic [TW-1:0] rs2_query_tag,
  output logic          rs1_rob_ready,
  output logic          rs2_rob_ready,
  output logic [31:0]   rs1_rob_v,
  output logic [31:0]   rs2_rob_v,
  output logic          rob_commit,
  output logic          rob_commit_regf_we,
  output logic [4:0]    rob_commit_rd_s,
  output logic [31:0]   rob_commit_rd_v,
  output logic [TW-1:0] rob_commit_tag,
  output logic          flush,
  output logic [31:0]   flush_pc
);
  logic [TW:0]          r_head;
  logic [TW:0]          r_tail;
  logic [ROB_DEPTH-1:0] r_valid;
  logic [ROB_DEPTH-1:0] r_done;
  logic [ROB_DEPTH-1:0] r_mis;
  logic [ROB_DEPTH-1:0] r_we;
  logic [4:0]           r_rd  [ROB_DEPTH];
  logic [31:0]          r_val [ROB_DEPTH];
  logic [31:0]          r_tgt [ROB_DEPTH];

  logic [TW-1:0] w_head_idx;
  logic [TW-1:0] w_tail_idx;
  logic          w_full;
  logic          w_commit;
  logic          w_flush;
  logic          w_alloc;
  logic          w_wb;
  logic          w_rs1_byp;
  logic          w_rs2_byp;

  assign w_head_idx = r_head[TW-1:0];
  assign w_tail_idx = r_tail[TW-1:0];
  assign w_full     = (r_head[TW-1:0] == r_tail[TW-1:0]) && (r_head[TW] != r_tail[TW]);
  assign w_commit   = r_valid[w_head_idx] && r_done[w_head_idx];
  assign w_flush    = w_commit && r_mis[w_head_idx];
  assign w_alloc    = iq_issue && !w_full && !w_flush;
  // A result aimed at the slot being (re)allocated this cycle is stale; allocation wins.
  assign w_wb       = cdb_valid && r_valid[cdb_tag] && !w_flush &&
                      !(w_alloc && (cdb_tag == w_tail_idx));

  assign rob_full       = w_full;
  assign rob_empty      = (r_head == r_tail);
  assign rob_issue_tag  = w_tail_idx;
  assign rob_issue_rd_s = rst ? issue_rd_s : 5'd0;

  assign rob_commit         = w_commit;
  assign rob_commit_regf_we = w_commit && r_we[w_head_idx];
  assign rob_commit_rd_s    = w_commit ? r_rd[w_head_idx]  : 5'd0;
  assign rob_commit_rd_v    = w_commit ? r_val[w_head_idx] : 32'd0;
  assign rob_commit_tag     = w_head_idx;
  assign flush              = w_flush;
  assign flush_pc           = w_flush ? r_tgt[w_head_idx] : 32'd0;

  // Operand lookup with same-cycle CDB bypass for entries still in flight.
  assign w_rs1_byp     = cdb_valid && (cdb_tag == rs1_query_tag) && r_valid[rs1_query_tag];
  assign w_rs2_byp     = cdb_valid && (cdb_tag == rs2_query_tag) && r_valid[rs2_query_tag];
  assign rs1_rob_ready = w_rs1_byp || (r_valid[rs1_query_tag] && r_done[rs1_query_tag]);
  assign rs2_rob_ready = w_rs2_byp || (r_valid[rs2_query_tag] && r_done[rs2_query_tag]);
  assign rs1_rob_v     = w_rs1_byp ? cdb_v : r_val[rs1_query_tag];
  assign rs2_rob_v     = w_rs2_byp ? cdb_v : r_val[rs2_query_tag];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
      r_mis   <= '0;
      r_we    <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_rd[i]  <= '0;
        r_val[i] <= '0;
        r_tgt[i] <= '0;
      end
    end else if (w_flush) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      if (w_wb) begin
        r_done[cdb_tag] <= 1'b1;
        r_mis[cdb_tag]  <= cdb_mispredict;
        r_val[cdb_tag]  <= cdb_v;
        r_tgt[cdb_tag]  <= cdb_target;
      end
      if (w_commit) begin
        r_valid[w_head_idx] <= 1'b0;
        r_head              <= r_head + (TW+1)'(1);
      end
      if (w_alloc) begin
        r_valid[w_tail_idx] <= 1'b1;
        r_done[w_tail_idx]  <= 1'b0;
        r_mis[w_tail_idx]   <= 1'b0;
        r_we[w_tail_idx]    <= issue_regf_we;
        r_rd[w_tail_idx]    <= issue_rd_s;
        r_tail              <= r_tail + (TW+1)'(1);
      end
    end
  end

endmodule
